// File: rtl/mux_scan_ctrl.sv
// Channel scanner in front of a 2**swidth:1 mux: walks the enabled channels,
// samples the mux output one cycle after each select change, and hands words out over valid/ready.
module mux_scan_ctrl #(
  parameter int width  = 4,
  parameter int swidth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     stop,
  input  logic [(1<<swidth)-1:0]   en_mask,
  input  logic [width-1:0]         mux_o,
  output logic [swidth-1:0]        sel,
  output logic [width-1:0]         out_data,
  output logic [swidth-1:0]        out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int nch = 1 << swidth;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [nch-1:0]      mask_q, mask_d;
  logic                mode_q, mode_d;
  logic                stop_req_q, stop_req_d;
  logic [swidth-1:0]   sel_q, sel_d;
  logic [width-1:0]    out_data_q, out_data_d;
  logic [swidth-1:0]   out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Enabled channels strictly above the current select; feeds the next-channel search.
  logic [nch-1:0] above_mask;

  genvar gi;
  generate
    for (gi = 0; gi < nch; gi++) begin : g_above
      localparam logic [swidth-1:0] idx = swidth'(gi);
      assign above_mask[gi] = mask_q[gi] && (idx > sel_q);
    end
  endgenerate

  function automatic logic [swidth-1:0] lowest_set(input logic [nch-1:0] m);
    lowest_set = '0;
    for (int i = nch - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = swidth'(i);
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    stop_req_d  = stop_req_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    if (state_q != IDLE && stop) stop_req_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (|en_mask) begin
            mask_d     = en_mask;
            mode_d     = mode;
            stop_req_d = 1'b0;
            sel_d      = lowest_set(en_mask);
            state_d    = SETTLE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETTLE: begin
        out_data_d  = mux_o;
        out_ch_d    = sel_q;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (stop_req_q || stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (|above_mask) begin
            sel_d   = lowest_set(above_mask);
            state_d = SETTLE;
          end else if (mode_q) begin
            // Wrap back to the first enabled channel without an extra cycle.
            sel_d   = lowest_set(mask_q);
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      mode_q      <= 1'b0;
      stop_req_q  <= 1'b0;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      stop_req_q  <= stop_req_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed + randomized bench for mux_scan_ctrl; expected words come from the
// list of set mask bits and the mux rule data = (channel + 3) mod 16.
module tb_mux_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic        stop;
  logic [15:0] en_mask;
  logic [3:0]  mux_o;
  logic [3:0]  sel;
  logic [3:0]  out_data;
  logic [3:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  mux_scan_ctrl #(.width(4), .swidth(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .stop      (stop),
    .en_mask   (en_mask),
    .mux_o     (mux_o),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  // Mux stand-in: input k carries (k + 3) mod 16.
  assign mux_o = sel + 4'h3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_data(input int ch);
    return 4'((ch + 3) % 16);
  endfunction

  // Single sweep over mask m; bp randomizes out_ready to exercise backpressure.
  task automatic scan_single(input logic [15:0] m, input bit bp);
    int          q[$];
    int          n;
    int          t;
    int          tries;
    bit          rdy;
    logic [3:0]  h_ch, h_data, h_sel;
    for (int k = 0; k < 16; k++) if (m[k]) q.push_back(k);
    en_mask = m; mode = 1'b0; start = 1'b1; out_ready = 1'b1;
    step(); t = 1;
    start = 1'b0;
    en_mask = 16'($urandom); mode = 1'b1;
    chk("single_busy_start", busy, 1);
    chk("single_sel_first", sel, q[0]);
    for (int i = 0; i < q.size(); i++) begin
      n = 0;
      while (!out_valid && n < 8) begin
        if (bp) start = 1'($urandom_range(0, 1));
        step(); t++; n++;
      end
      chk("single_valid_seen", out_valid, 1);
      chk("single_ch", out_ch, q[i]);
      chk("single_data", out_data, exp_data(q[i]));
      tries = 0;
      do begin
        rdy = bp && tries < 10 ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = rdy;
        if (bp) start = 1'($urandom_range(0, 1));
        h_ch = out_ch; h_data = out_data; h_sel = sel;
        step(); t++; tries++;
        if (!rdy) begin
          chk("bp_valid_hold", out_valid, 1);
          chk("bp_ch_hold", out_ch, h_ch);
          chk("bp_data_hold", out_data, h_data);
          chk("bp_sel_hold", sel, h_sel);
        end
      end while (!rdy);
      if (i < q.size() - 1) chk("single_no_early_done", done, 0);
    end
    start = 1'b0; out_ready = 1'b1;
    chk("single_done", done, 1);
    chk("single_idle_busy", busy, 0);
    chk("single_idle_valid", out_valid, 0);
    if (!bp) chk("single_latency", t, 2 * q.size() + 1);
    step();
    chk("single_done_pulse", done, 0);
    chk("single_sel_hold_idle", sel, q[q.size() - 1]);
    $display("single mask=%04h bp=%0d words=%0d steps=%0d", m, bp, q.size(), t);
  endtask

  // Continuous scan over mask m for nwords words; stop is raised mid-way through the last one.
  task automatic scan_cont(input logic [15:0] m, input int nwords);
    int q[$];
    int n;
    int ch;
    for (int k = 0; k < 16; k++) if (m[k]) q.push_back(k);
    en_mask = m; mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    en_mask = 16'($urandom); mode = 1'b0;
    chk("cont_busy_start", busy, 1);
    for (int i = 0; i < nwords; i++) begin
      ch = q[i % q.size()];
      n = 0;
      while (!out_valid && n < 8) begin
        step(); n++;
      end
      chk("cont_gap", n, 1);
      chk("cont_ch", out_ch, ch);
      chk("cont_data", out_data, exp_data(ch));
      if (i == nwords - 1) begin
        stop = 1'b1; out_ready = 1'b0;
        step();
        stop = 1'b0;
        chk("stop_word_held", out_valid, 1);
        chk("stop_still_busy", busy, 1);
      end
      out_ready = 1'b1;
      step();
      if (i < nwords - 1) begin
        chk("cont_busy", busy, 1);
        chk("cont_no_done", done, 0);
      end
    end
    chk("cont_done", done, 1);
    chk("cont_idle_busy", busy, 0);
    chk("cont_idle_valid", out_valid, 0);
    step();
    chk("cont_done_pulse", done, 0);
    $display("continuous mask=%04h words=%0d", m, nwords);
  endtask

  initial begin
    logic [15:0] m;
    rst = 1'b1; start = 1'b0; mode = 1'b0; stop = 1'b0;
    en_mask = 16'h0000; out_ready = 1'b0;
    step(); step();
    chk("rst_sel", sel, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    step();
    $display("reset released");

    // stop in IDLE does nothing
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle_stop_busy", busy, 0);
    chk("idle_stop_done", done, 0);

    scan_single(16'hFFFF, 1'b0);
    scan_single(16'h8421, 1'b0);
    scan_single(16'h0004, 1'b1);
    for (int r = 0; r < 4; r++) begin
      m = 16'($urandom_range(1, 65535));
      scan_single(m, 1'b1);
    end

    scan_cont(16'h0003, 6);
    scan_cont(16'(1 << $urandom_range(0, 15)), 4);
    m = 16'($urandom_range(1, 65535));
    scan_cont(m, 2 * $countones(m) + 1);

    // start with empty mask: done pulse only
    en_mask = 16'h0000; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_valid", out_valid, 0);
    step();
    chk("zero_done_pulse", done, 0);
    chk("zero_valid_after", out_valid, 0);
    $display("zero mask start");

    // reset while a word is pending
    en_mask = 16'hFFFF; mode = 1'b0; start = 1'b1; out_ready = 1'b0;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    step();
    chk("midrst_sel", sel, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_ch", out_ch, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    step();
    chk("postrst_done", done, 0);
    chk("postrst_busy", busy, 0);
    chk("postrst_valid", out_valid, 0);
    $display("reset mid-scan");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Channel scanner that sits directly upstream of the 16:1 `width`-bit mux. It drives the mux select, samples the mux output, and emits one `{channel, data}` word per enabled channel over a valid/ready handshake. It supports a single sweep or continuous scanning over a latched 16-bit channel-enable mask, so a downstream consumer can read all mux inputs in turn without handling `sel` timing itself.

## Interface
- `width`, default 4: data width of the mux inputs and output.
- `swidth`, default 4: select width. The channel count is 2**`swidth` = 16, and the mask width equals the channel count.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: begins a scan when sampled high in IDLE; ignored otherwise.
- `mode`, input, 1: 0 = single sweep, 1 = continuous. Latched on an accepted `start`.
- `stop`, input, 1: request to end a continuous scan. Latched as `stop_req` while busy.
- `en_mask`, input, 16: channel enable, bit k enables channel k. Latched on an accepted `start`.
- `mux_o`, input, `width`: the mux output (a combinational function of `sel`).
- `sel`, output, `swidth`: registered mux select.
- `out_data`, output, `width`: captured sample.
- `out_ch`, output, `swidth`: channel index of `out_data`.
- `out_valid`, output, 1: the output word is valid.
- `out_ready`, input, 1: the consumer accepts the word.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done`, output, 1: one-cycle pulse marking the end of a scan.

## Operation
- States are IDLE, SETTLE and OUTPUT.
- **IDLE**
  - On `start`=1 with latched-to-be `en_mask`≠0: latch `mask` and `mode`, clear `stop_req`, set `sel` to the lowest set mask bit, and go to SETTLE.
  - On `start`=1 with `en_mask`=0: pulse `done` on the next cycle and stay in IDLE.
- **SETTLE** (lasts exactly 1 cycle)
  - `sel` is stable for the whole cycle.
  - At the exit edge: `out_data`<=`mux_o`, `out_ch`<=`sel`, `out_valid`<=1, then go to OUTPUT.
- **OUTPUT**
  - Hold `out_data`, `out_ch` and `out_valid` stable until `out_valid`&`out_ready` is sampled high.
  - At the handshake edge, `out_valid`<=0, then:
    - If `stop_req`, or `stop` is high at that edge: go to IDLE and pulse `done`.
    - Else if an enabled channel exists with index > `sel`: set `sel` to the nearest such channel and go to SETTLE.
    - Else (wrap-around), if `mode`=1: set `sel` to the lowest enabled channel and go to SETTLE.
    - Else (`mode`=0): go to IDLE and pulse `done`.
- Disabled channels are skipped with no cycle cost; the next-channel search is combinational priority logic over the 16-bit mask.
- `mask`/`mode` changes on the inputs during a scan have no effect until the next accepted `start`.
- `start` while busy is ignored.
- `stop` in IDLE is ignored.
- In IDLE, `sel` holds its last value.
- `busy` and `done` are registered; `done` is high in the first IDLE cycle only.

## Timing
- **Reset values:** `sel`=0, `out_data`=0, `out_ch`=0, `out_valid`=0, `busy`=0, `done`=0, state IDLE, `stop_req`=0.
- **Reset mid-scan:** aborts immediately, including a pending word. No `done` pulse.
- **Start latency:** `start` is sampled at edge E0. `sel`/`busy` update after E0, and `out_valid` rises after E1 (2 cycles).
- **Throughput:** with `out_ready` held high, one word per 2 cycles, so a 16-channel sweep takes 32 cycles from E0 to the `done` edge.
- **Backpressure:** `out_ready` low stretches OUTPUT indefinitely, and the data stays frozen. The handshake occurs only when `out_valid`=1.
- **Continuous wrap:** wrap-around costs no extra cycle; it behaves like any channel step.
- **Single-channel mask:** the same channel repeats in continuous mode, and one word is emitted in single mode.

## Test plan
- **Full sweep.** Bench mux model: `mux_o` = (`sel`+4'h3)&4'hF; `en_mask`=16'hFFFF, `mode`=0, `out_ready`=1, pulse `start`.
  - Expect 16 words in order `out_ch` 0..15 with `out_data` 3,4,…,F,0,1,2.
  - Expect `done` 32 cycles after the `start` edge, then `busy`=0.
- **Sparse mask.** `en_mask`=16'h8421, `mode`=0.
  - Expect exactly 4 words with `out_ch` 0,5,10,15 and correct data, then `done`.
- **Backpressure.** `out_ready` low for 5 cycles while `out_valid`=1 on channel 2.
  - `out_data`/`out_ch` stay constant, and no `sel` change occurs until the handshake.
- **Continuous and stop.** `en_mask`=16'h0003, `mode`=1.
  - Expect channel sequence 0,1,0,1,….
  - Assert `stop` mid-word on channel 1: that word completes, then `done` pulses and the FSM returns to IDLE.
- **Edge cases.**
  - `start` with `en_mask`=0 gives a `done` pulse and no `out_valid`.
  - `start` re-pulsed while busy changes nothing.
  - `rst` asserted in OUTPUT gives all outputs at reset values on the next cycle.
